// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Ports: req{0,1} valid/ready/a/b/op in, rsp{0,1} valid/ready/data out, alu_* mux, busy_cnt.
module alu_arbiter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [3:0]   req0_op,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic [3:0]   req1_op,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic [W-1:0] rsp0_data,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [W-1:0] rsp1_data,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [3:0]   alu_op,
  input  logic [W-1:0] alu_out,
  output logic [15:0]  busy_cnt
);

  logic         prio_q, prio_d;
  logic         v0_q, v0_d;
  logic         v1_q, v1_d;
  logic [W-1:0] d0_q, d0_d;
  logic [W-1:0] d1_q, d1_d;
  logic [15:0]  busy_q, busy_d;

  logic elig0, elig1;
  logic gnt0, gnt1;
  logic sel1;

  // A port may issue when its response slot is empty or drains now.
  assign elig0 = req0_valid & (~v0_q | rsp0_ready);
  assign elig1 = req1_valid & (~v1_q | rsp1_ready);

  // Grants are suppressed while reset is held so ready stays low.
  assign gnt0 = rst_n & elig0 & (~elig1 | ~prio_q);
  assign gnt1 = rst_n & elig1 & (~elig0 | prio_q);

  // Idle cycles park the mux on the port holding priority.
  assign sel1 = gnt1 | (~gnt0 & prio_q);

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  assign alu_a  = sel1 ? req1_a  : req0_a;
  assign alu_b  = sel1 ? req1_b  : req0_b;
  assign alu_op = sel1 ? req1_op : req0_op;

  always_comb begin
    prio_d = prio_q;
    v0_d   = v0_q;
    v1_d   = v1_q;
    d0_d   = d0_q;
    d1_d   = d1_q;
    busy_d = busy_q;

    unique case (1'b1)
      gnt0:    prio_d = 1'b1;
      gnt1:    prio_d = 1'b0;
      default: prio_d = prio_q;
    endcase

    if (gnt0) begin
      v0_d = 1'b1;
      d0_d = alu_out;
    end else if (rsp0_ready) begin
      v0_d = 1'b0;
    end

    if (gnt1) begin
      v1_d = 1'b1;
      d1_d = alu_out;
    end else if (rsp1_ready) begin
      v1_d = 1'b0;
    end

    if (elig0 && elig1 && busy_q != 16'hFFFF)
      busy_d = busy_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
      v0_q   <= 1'b0;
      v1_q   <= 1'b0;
      d0_q   <= '0;
      d1_q   <= '0;
      busy_q <= '0;
    end else begin
      prio_q <= prio_d;
      v0_q   <= v0_d;
      v1_q   <= v1_d;
      d0_q   <= d0_d;
      d1_q   <= d1_d;
      busy_q <= busy_d;
    end
  end

  assign rsp0_valid = v0_q;
  assign rsp1_valid = v1_q;
  assign rsp0_data  = d0_q;
  assign rsp1_data  = d1_q;
  assign busy_cnt   = busy_q;

endmodule
